// File: rtl/cam_arbiter.sv
// cam_arbiter: two-client round-robin front end for one shared CAM
// priority-lookup unit. A request is accepted in IDLE, issued to the CAM for
// one cycle, the registered CAM result is captured, and the result is then
// held on the owning client's response channel until that client takes it.
//
// Optional build macro CAM_ARB_STATS_EN adds per-client saturating grant
// counters (grant_cnt0/grant_cnt1) with a synchronous clear input (stats_clr).
module cam_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = (1 << ADDR_WIDTH),
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DEPTH-1:0]      req0_vec,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DEPTH-1:0]      req1_vec,
  output logic                  resp0_valid,
  input  logic                  resp0_ready,
  output logic                  resp1_valid,
  input  logic                  resp1_ready,
  output logic                  resp_hit,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  cam_enable,
  output logic [DEPTH-1:0]      cam_data,
  input  logic                  cam_hit,
  input  logic [ADDR_WIDTH-1:0] cam_addr
`ifdef CAM_ARB_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [CNT_WIDTH-1:0]  grant_cnt0,
  output logic [CNT_WIDTH-1:0]  grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // owner: client whose lookup is in flight; last_grant: 1 means client 1
  // was granted most recently, so client 0 wins the next contention.
  logic owner;
  logic last_grant;
  logic grant0;
  logic grant1;
  logic hs0;
  logic hs1;
  logic resp_take;

  // Round-robin grant from the live valids; only meaningful in IDLE.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign hs0       = req0_valid && req0_ready;
  assign hs1       = req1_valid && req1_ready;
  assign resp_take = owner ? resp1_ready : resp0_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one lookup in flight at a time, fixed ISSUE/CAPTURE timing.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hs0 || hs1) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        if (resp_take) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: handshake readies, CAM strobe and owner-steered response valid.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    cam_enable  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
      end
      ISSUE: begin
        cam_enable = 1'b1;
      end
      RESP: begin
        resp0_valid = !owner;
        resp1_valid = owner;
      end
      default: begin
      end
    endcase
  end

  // Request capture: latch the winning vector, its owner and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cam_data   <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (state == IDLE) begin
      if (hs0) begin
        cam_data   <= req0_vec;
        owner      <= 1'b0;
        last_grant <= 1'b0;
      end else if (hs1) begin
        cam_data   <= req1_vec;
        owner      <= 1'b1;
        last_grant <= 1'b1;
      end
    end
  end

  // Result capture: the CAM output is only valid in the cycle after ISSUE,
  // so it is sampled once in CAPTURE and held for the whole response phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_hit  <= 1'b0;
      resp_addr <= '0;
    end else if (state == CAPTURE) begin
      resp_hit  <= cam_hit;
      resp_addr <= cam_addr;
    end
  end

`ifdef CAM_ARB_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Grant counters: clear wins over a same-cycle increment; saturate at all-ones.
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (hs0) begin
        grant_cnt0 <= sat_inc(grant_cnt0);
      end
      if (hs1) begin
        grant_cnt1 <= sat_inc(grant_cnt1);
      end
    end
  end
`else
  // Counter width is only consumed by the statistics build.
  logic [CNT_WIDTH-1:0] stats_unused;
  assign stats_unused = '0;
`endif

endmodule
